// File: rtl/prbs7_checker_if.sv
// rtl/prbs7_checker_if.sv - receive stream, control and status bundle for prbs7_checker.
// PRBS_CHK_BITCNT_EN adds the bit_cnt status field.
interface prbs7_checker_if #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 32
);
  localparam int EB_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             clear;
  logic             locked;
  logic             word_err;
  logic [EB_W-1:0]  word_err_bits;
  logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
  logic [47:0]      bit_cnt;

  modport master (
    output data_in, data_valid, clear,
    input  locked, word_err, word_err_bits, err_cnt, bit_cnt
  );
  modport slave (
    input  data_in, data_valid, clear,
    output locked, word_err, word_err_bits, err_cnt, bit_cnt
  );
`else
  modport master (
    output data_in, data_valid, clear,
    input  locked, word_err, word_err_bits, err_cnt
  );
  modport slave (
    input  data_in, data_valid, clear,
    output locked, word_err, word_err_bits, err_cnt
  );
`endif
endinterface

// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - self-synchronising PRBS7 (x^7+x^6+1) word checker with bit-error counting.
// PRBS_CHK_BITCNT_EN adds a saturating 48-bit count of bits checked while locked.
module prbs7_checker #(
  parameter int WIDTH      = 24,
  parameter int TAP1       = 6,
  parameter int TAP2       = 5,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  prbs7_checker_if.slave  bus
);
  localparam int EB_W = $clog2(WIDTH + 1);
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int UC_W = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {HUNT, LOCK} state_e;

  state_e           state_q, state_d;
  logic [6:0]       pred_q, pred_d;
  logic [6:0]       prev_q, prev_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [UC_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             word_err_q, word_err_d;
  logic [EB_W-1:0]  word_err_bits_q, word_err_bits_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
`ifdef PRBS_CHK_BITCNT_EN
  logic [47:0]      bit_cnt_q, bit_cnt_d;
`endif

  function automatic logic [WIDTH-1:0] step(input logic [6:0] seed);
    logic [6:0]       s;
    logic [WIDTH-1:0] w;
    logic             b;
    s = seed;
    w = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      b    = s[TAP1] ^ s[TAP2];
      w[i] = b;
      s    = {s[5:0], b};
    end
    return w;
  endfunction

  function automatic logic [EB_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [EB_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + EB_W'(v[i]);
    return n;
  endfunction

  logic [WIDTH-1:0] exp_hunt, exp_lock;
  logic [EB_W-1:0]  err_bits;
  logic [CNT_W:0]   err_sum;

  always_comb begin
    exp_hunt = step(prev_q);
    exp_lock = step(pred_q);
    err_bits = popcount(bus.data_in ^ exp_lock);
    err_sum  = {1'b0, err_cnt_q} + {{(CNT_W + 1 - EB_W){1'b0}}, err_bits};

    state_d         = state_q;
    pred_d          = pred_q;
    prev_d          = prev_q;
    match_cnt_d     = match_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    locked_d        = locked_q;
    word_err_d      = 1'b0;
    word_err_bits_d = word_err_bits_q;
    err_cnt_d       = err_cnt_q;
`ifdef PRBS_CHK_BITCNT_EN
    bit_cnt_d       = bit_cnt_q;
`endif

    if (bus.data_valid) begin
      prev_d = bus.data_in[6:0];
      if (state_q == HUNT) begin
        word_err_bits_d = '0;
        // A zero seed regenerates only zeros, so it can never prove alignment.
        if (prev_q != 7'd0 && bus.data_in == exp_hunt) begin
          if (match_cnt_q == MC_W'(LOCK_CNT - 1)) begin
            state_d     = LOCK;
            locked_d    = 1'b1;
            pred_d      = bus.data_in[6:0];
            match_cnt_d = '0;
            miss_cnt_d  = '0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end else begin
          match_cnt_d = '0;
        end
      end else begin
        // Advance from the prediction, so one bad bit is counted once.
        pred_d          = exp_lock[6:0];
        word_err_bits_d = err_bits;
        word_err_d      = (err_bits != '0);
        err_cnt_d       = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
`ifdef PRBS_CHK_BITCNT_EN
        bit_cnt_d = (bit_cnt_q > 48'hFFFF_FFFF_FFFF - 48'(WIDTH)) ? '1 : bit_cnt_q + 48'(WIDTH);
`endif
        if (err_bits != '0) begin
          if (miss_cnt_q == UC_W'(UNLOCK_CNT - 1)) begin
            state_d     = HUNT;
            locked_d    = 1'b0;
            miss_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end else begin
          miss_cnt_d = '0;
        end
      end
    end

    if (bus.clear) begin
      err_cnt_d       = '0;
      word_err_bits_d = '0;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt_d       = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= HUNT;
      pred_q          <= '0;
      prev_q          <= '0;
      match_cnt_q     <= '0;
      miss_cnt_q      <= '0;
      locked_q        <= 1'b0;
      word_err_q      <= 1'b0;
      word_err_bits_q <= '0;
      err_cnt_q       <= '0;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      pred_q          <= pred_d;
      prev_q          <= prev_d;
      match_cnt_q     <= match_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      locked_q        <= locked_d;
      word_err_q      <= word_err_d;
      word_err_bits_q <= word_err_bits_d;
      err_cnt_q       <= err_cnt_d;
`ifdef PRBS_CHK_BITCNT_EN
      bit_cnt_q       <= bit_cnt_d;
`endif
    end
  end

  assign bus.locked        = locked_q;
  assign bus.word_err      = word_err_q;
  assign bus.word_err_bits = word_err_bits_q;
  assign bus.err_cnt       = err_cnt_q;
`ifdef PRBS_CHK_BITCNT_EN
  assign bus.bit_cnt       = bit_cnt_q;
`endif
endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - directed bench for prbs7_checker; PRBS_CHK_BITCNT_EN adds the bit_cnt test.
module tb_prbs7_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   gi = 0;
  bit   seq [24*128];

  always #5 clk = ~clk;

  prbs7_checker_if #(.WIDTH(24), .CNT_W(32)) bus ();

  prbs7_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference stream as the recurrence x[n] = x[n-7] ^ x[n-6], word 0 = 0x000001.
  function automatic logic [23:0] gw(input int k);
    int kk;
    logic [23:0] w;
    kk = (k == 0) ? 0 : ((k - 1) % 127) + 1;
    for (int i = 0; i < 24; i++) w[23-i] = seq[24*kk + i];
    return w;
  endfunction

  task automatic cyc(input logic [23:0] d, input logic v, input logic c);
    bus.data_in    = d;
    bus.data_valid = v;
    bus.clear      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) cyc(24'h123456, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("reset_locked", 64'(bus.locked), 64'd0);
    chk("reset_word_err", 64'(bus.word_err), 64'd0);
    chk("reset_word_err_bits", 64'(bus.word_err_bits), 64'd0);
    chk("reset_err_cnt", 64'(bus.err_cnt), 64'd0);
    chk("gen_word0", 64'(gw(0)), 64'h000001);
    chk("gen_word1", 64'(gw(1)), 64'h061479);
  endtask

  task automatic test_lock_acquire;
    for (int i = 0; i < 5; i++) begin
      cyc(gw(gi), 1'b1, 1'b0);
      gi++;
      if (i == 3) chk("lock_not_yet", 64'(bus.locked), 64'd0);
    end
    chk("lock_after_5", 64'(bus.locked), 64'd1);
    chk("lock_err_cnt", 64'(bus.err_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(gw(gi), 1'b1, 1'b0);
      gi++;
    end
    chk("clean_word_err", 64'(bus.word_err), 64'd0);
    chk("clean_err_cnt", 64'(bus.err_cnt), 64'd0);
  endtask

  task automatic test_bit_flip;
    cyc(gw(gi) ^ 24'h800001, 1'b1, 1'b0);
    gi++;
    chk("flip_word_err", 64'(bus.word_err), 64'd1);
    chk("flip_bits", 64'(bus.word_err_bits), 64'd2);
    chk("flip_err_cnt", 64'(bus.err_cnt), 64'd2);
    chk("flip_locked", 64'(bus.locked), 64'd1);
    cyc(gw(gi), 1'b1, 1'b0);
    gi++;
    chk("flip_next_word_err", 64'(bus.word_err), 64'd0);
    chk("flip_next_bits", 64'(bus.word_err_bits), 64'd0);
    chk("flip_next_err_cnt", 64'(bus.err_cnt), 64'd2);
  endtask

  task automatic test_clear;
    cyc(gw(gi) ^ 24'h000007, 1'b1, 1'b0);
    gi++;
    chk("pre_clear_err_cnt", 64'(bus.err_cnt), 64'd5);
    chk("pre_clear_bits", 64'(bus.word_err_bits), 64'd3);
    cyc(gw(gi) ^ 24'h070000, 1'b1, 1'b1);
    gi++;
    chk("clear_err_cnt", 64'(bus.err_cnt), 64'd0);
    chk("clear_bits", 64'(bus.word_err_bits), 64'd0);
    chk("clear_word_err", 64'(bus.word_err), 64'd1);
    chk("clear_locked", 64'(bus.locked), 64'd1);
    cyc(gw(gi), 1'b1, 1'b0);
    gi++;
    chk("post_clear_err_cnt", 64'(bus.err_cnt), 64'd0);
  endtask

  task automatic test_unlock_relock;
    for (int i = 0; i < 4; i++) begin
      cyc(24'hFFFFFF, 1'b1, 1'b0);
      gi++;
      if (i == 2) chk("unlock_hold_3", 64'(bus.locked), 64'd1);
    end
    chk("unlock_after_4", 64'(bus.locked), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(gw(gi), 1'b1, 1'b0);
      gi++;
      if (i == 3) chk("relock_not_yet", 64'(bus.locked), 64'd0);
    end
    chk("relock_after_5", 64'(bus.locked), 64'd1);
  endtask

  task automatic test_reset_locked;
    rst_n = 1'b0;
    cyc(gw(gi) ^ 24'h00F000, 1'b1, 1'b0);
    gi++;
    rst_n = 1'b1;
    chk("rst_locked", 64'(bus.locked), 64'd0);
    chk("rst_word_err", 64'(bus.word_err), 64'd0);
    chk("rst_bits", 64'(bus.word_err_bits), 64'd0);
    chk("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
  endtask

  task automatic test_zero;
    logic seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(24'h000000, 1'b1, 1'b0);
      seen = seen | bus.locked;
    end
    chk("zero_never_locked", 64'(seen), 64'd0);
    chk("zero_err_cnt", 64'(bus.err_cnt), 64'd0);
  endtask

  task automatic test_toggle;
    for (int i = 0; i < 5; i++) begin
      cyc(gw(gi), 1'b1, 1'b0);
      gi++;
      if (i == 3) chk("toggle_not_yet", 64'(bus.locked), 64'd0);
      if (i == 4) chk("toggle_locked", 64'(bus.locked), 64'd1);
      cyc(24'hABCDEF, 1'b0, 1'b0);
    end
    chk("toggle_idle_locked", 64'(bus.locked), 64'd1);
    chk("toggle_idle_word_err", 64'(bus.word_err), 64'd0);
    cyc(gw(gi) ^ 24'h000010, 1'b1, 1'b0);
    gi++;
    chk("toggle_pulse", 64'(bus.word_err), 64'd1);
    cyc(24'h555555, 1'b0, 1'b0);
    chk("toggle_pulse_drop", 64'(bus.word_err), 64'd0);
    chk("toggle_bits_hold", 64'(bus.word_err_bits), 64'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(gw(gi), 1'b1, 1'b0);
      gi++;
      cyc(24'h0F0F0F, 1'b0, 1'b0);
    end
    chk("toggle_clean_bits", 64'(bus.word_err_bits), 64'd0);
    chk("toggle_err_cnt", 64'(bus.err_cnt), 64'd1);
  endtask

`ifdef PRBS_CHK_BITCNT_EN
  task automatic test_bitcnt;
    cyc(24'h000000, 1'b0, 1'b1);
    chk("bitcnt_cleared", 64'(bus.bit_cnt), 64'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(gw(gi), 1'b1, 1'b0);
      gi++;
    end
    chk("bitcnt_240", 64'(bus.bit_cnt), 64'd240);
  endtask
`endif

  initial begin
    for (int i = 0; i < 24; i++) seq[i] = (i == 23);
    for (int n = 24; n < 24*128; n++) seq[n] = seq[n-7] ^ seq[n-6];
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.clear      = 1'b0;
    test_reset();
    test_lock_acquire();
    test_bit_flip();
    test_clear();
    test_unlock_relock();
    test_reset_locked();
    test_zero();
    test_toggle();
`ifdef PRBS_CHK_BITCNT_EN
    test_bitcnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
